// File: rtl/cache_mem_arbiter.sv
// Single-port memory arbiter between the instruction cache (read-only) and data cache (read/write).
// Optional macro ARB_ROUND_ROBIN_EN alternates the grant when both caches request together.
module cache_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic              grant_sel
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              grant_q, grant_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              d_req_s;
   logic              pick_d_s;

   assign d_req_s = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_q;

   // Under contention the cache not served last wins; a lone requester always wins.
   assign pick_d_s = d_req_s & (~i_read | ~last_grant_q);

   // Remember which cache received the most recent grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant_q <= 1'b0;
      end else if ((state_q == IDLE) && (d_req_s || i_read)) begin
         last_grant_q <= pick_d_s;
      end else begin
         last_grant_q <= last_grant_q;
      end
   end
`else
   assign pick_d_s = d_req_s;
`endif

   // Next-state, grant capture and strobe control.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      grant_d = grant_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      case (state_q)
         IDLE: begin
            if (pick_d_s) begin
               state_d = SERVE_D;
               addr_d  = d_address;
               grant_d = 1'b1;
               if (d_write) begin
                  // A simultaneous read+write is resolved as a write.
                  wr_d    = 1'b1;
                  rd_d    = 1'b0;
                  wdata_d = d_wdata;
               end else begin
                  wr_d = 1'b0;
                  rd_d = 1'b1;
               end
            end else if (i_read) begin
               state_d = SERVE_I;
               addr_d  = i_address;
               grant_d = 1'b0;
               rd_d    = 1'b1;
               wr_d    = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         SERVE_I, SERVE_D: begin
            if (mem_resp) begin
               state_d = IDLE;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
         end
      endcase
   end

   // State and transaction registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         grant_q <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         grant_q <= grant_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   assign mem_read    = rd_q;
   assign mem_write   = wr_q;
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;
   assign grant_sel   = grant_q;

   // Completion is routed only to the owner of the port; the other side sees zeros.
   assign i_resp  = (state_q == SERVE_I) & mem_resp;
   assign d_resp  = (state_q == SERVE_D) & mem_resp;
   assign i_rdata = i_resp ? mem_rdata : {LINE_W{1'b0}};
   assign d_rdata = d_resp ? mem_rdata : {LINE_W{1'b0}};

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: vector table, directed corner sequences,
// and randomized transactions checked against a transaction-level reference model.
module tb_cache_mem_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk;
   logic          rst;
   logic          i_read;
   logic [AW-1:0] i_address;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_address;
   logic [LW-1:0] d_wdata;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata;
   logic          mem_resp;
   logic          grant_sel;

   int checks = 0;
   int errors = 0;

   cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .grant_sel(grant_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit ir;
      bit dr;
      bit dw;
      bit e_rd;
      bit e_wr;
      bit e_gs;
      bit e_iresp;
      bit e_dresp;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      i_read    = 1'b0;
      i_address = '0;
      d_read    = 1'b0;
      d_write   = 1'b0;
      d_address = '0;
      d_wdata   = '0;
      mem_rdata = '0;
      mem_resp  = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   vec_t          vecs[8];
   logic [LW-1:0] pat;
   logic [LW-1:0] exp_wdata;
   bit            last_d;
   bit            win_d;
   bit            is_wr;
   bit            exp_g;

   initial begin
      vecs[0] = '{ir:0, dr:0, dw:0, e_rd:0, e_wr:0, e_gs:0, e_iresp:0, e_dresp:0};
      vecs[1] = '{ir:1, dr:0, dw:0, e_rd:1, e_wr:0, e_gs:0, e_iresp:1, e_dresp:0};
      vecs[2] = '{ir:0, dr:1, dw:0, e_rd:1, e_wr:0, e_gs:1, e_iresp:0, e_dresp:1};
      vecs[3] = '{ir:0, dr:0, dw:1, e_rd:0, e_wr:1, e_gs:1, e_iresp:0, e_dresp:1};
      vecs[4] = '{ir:1, dr:1, dw:0, e_rd:1, e_wr:0, e_gs:1, e_iresp:0, e_dresp:1};
      vecs[5] = '{ir:1, dr:0, dw:1, e_rd:0, e_wr:1, e_gs:1, e_iresp:0, e_dresp:1};
      vecs[6] = '{ir:0, dr:1, dw:1, e_rd:0, e_wr:1, e_gs:1, e_iresp:0, e_dresp:1};
      vecs[7] = '{ir:1, dr:1, dw:1, e_rd:0, e_wr:1, e_gs:1, e_iresp:0, e_dresp:1};

      rst = 1'b0;
      clear_inputs();
      #2;
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_write", mem_write, 1'b0);
      chk("rst_grant", grant_sel, 1'b0);
      chk("rst_addr", mem_address, '0);
      chk("rst_wdata", mem_wdata, '0);

      // ---------------- table-driven single transactions
      for (int v = 0; v < 8; v++) begin
         do_reset();
         if (vecs[v].dr && vecs[v].dw)
            $display("note: vector %0d drives d_read and d_write together (protocol violation)", v);
         i_read    = vecs[v].ir;
         d_read    = vecs[v].dr;
         d_write   = vecs[v].dw;
         i_address = 32'h0000_1000 + 32'(v * 64);
         d_address = 32'h0000_2000 + 32'(v * 64);
         d_wdata   = {8{32'hC0DE_0000 + 32'(v)}};
         tick();
         chk($sformatf("v%0d_mem_read", v), mem_read, vecs[v].e_rd);
         chk($sformatf("v%0d_mem_write", v), mem_write, vecs[v].e_wr);
         chk($sformatf("v%0d_grant", v), grant_sel, vecs[v].e_gs);
         if (vecs[v].e_rd || vecs[v].e_wr)
            chk($sformatf("v%0d_addr", v), mem_address, vecs[v].e_gs ? d_address : i_address);
         else
            chk($sformatf("v%0d_addr", v), mem_address, '0);
         chk($sformatf("v%0d_wdata", v), mem_wdata, vecs[v].e_wr ? d_wdata : '0);
         tick();
         pat       = {8{32'h5A5A_0000 + 32'(v)}};
         mem_rdata = pat;
         mem_resp  = 1'b1;
         #1;
         chk($sformatf("v%0d_i_resp", v), i_resp, vecs[v].e_iresp);
         chk($sformatf("v%0d_d_resp", v), d_resp, vecs[v].e_dresp);
         chk($sformatf("v%0d_i_rdata", v), i_rdata, vecs[v].e_iresp ? pat : '0);
         chk($sformatf("v%0d_d_rdata", v), d_rdata, vecs[v].e_dresp ? pat : '0);
         tick();
         clear_inputs();
         chk($sformatf("v%0d_strobes_done", v), {mem_read, mem_write}, 2'b00);
      end

      // ---------------- icache read alone, cycle-accurate
      do_reset();
      i_read    = 1'b1;
      i_address = 32'h0000_0060;
      tick();
      chk("ic_c1_read", mem_read, 1'b1);
      chk("ic_c1_write", mem_write, 1'b0);
      chk("ic_c1_addr", mem_address, 32'h0000_0060);
      chk("ic_c1_grant", grant_sel, 1'b0);
      tick();
      tick();
      chk("ic_c3_read", mem_read, 1'b1);
      tick();
      mem_rdata = {32{8'hA5}};
      mem_resp  = 1'b1;
      #1;
      chk("ic_c4_i_resp", i_resp, 1'b1);
      chk("ic_c4_i_rdata", i_rdata, {32{8'hA5}});
      chk("ic_c4_d_resp", d_resp, 1'b0);
      chk("ic_c4_d_rdata", d_rdata, '0);
      tick();
      clear_inputs();
      chk("ic_c5_read", mem_read, 1'b0);

      // ---------------- conflict: dcache write first, then icache after one idle cycle
      do_reset();
      i_read    = 1'b1;
      i_address = 32'h0000_0100;
      d_write   = 1'b1;
      d_address = 32'h0000_0200;
      d_wdata   = {8{32'h1234_5678}};
      tick();
      chk("cf_d_write", mem_write, 1'b1);
      chk("cf_d_read", mem_read, 1'b0);
      chk("cf_d_addr", mem_address, 32'h0000_0200);
      chk("cf_d_wdata", mem_wdata, {8{32'h1234_5678}});
      chk("cf_d_grant", grant_sel, 1'b1);
      tick();
      mem_resp = 1'b1;
      #1;
      chk("cf_d_resp", d_resp, 1'b1);
      chk("cf_d_iresp", i_resp, 1'b0);
      tick();
      mem_resp = 1'b0;
      d_write  = 1'b0;
      chk("cf_idle_strobes", {mem_read, mem_write}, 2'b00);
      chk("cf_idle_grant_hold", grant_sel, 1'b1);
      tick();
      chk("cf_i_read", mem_read, 1'b1);
      chk("cf_i_addr", mem_address, 32'h0000_0100);
      chk("cf_i_grant", grant_sel, 1'b0);
      mem_rdata = {8{32'hDEAD_BEEF}};
      mem_resp  = 1'b1;
      #1;
      chk("cf_i_resp", i_resp, 1'b1);
      chk("cf_i_rdata", i_rdata, {8{32'hDEAD_BEEF}});
      tick();
      clear_inputs();

      // ---------------- requester inputs change during service
      do_reset();
      d_read    = 1'b1;
      d_address = 32'h0000_0200;
      tick();
      d_address = 32'h0000_0300;
      tick();
      chk("chg_addr_a", mem_address, 32'h0000_0200);
      tick();
      chk("chg_addr_b", mem_address, 32'h0000_0200);
      mem_resp = 1'b1;
      #1;
      chk("chg_d_resp", d_resp, 1'b1);
      chk("chg_addr_c", mem_address, 32'h0000_0200);
      tick();
      clear_inputs();

      // ---------------- asynchronous reset in the middle of a dcache write
      do_reset();
      d_write   = 1'b1;
      d_address = 32'h0000_0200;
      d_wdata   = {8{32'hFEED_F00D}};
      tick();
      chk("ar_pre_write", mem_write, 1'b1);
      rst = 1'b0;
      #1;
      chk("ar_write_cleared", mem_write, 1'b0);
      chk("ar_grant_cleared", grant_sel, 1'b0);
      chk("ar_addr_cleared", mem_address, '0);
      d_write = 1'b0;
      tick();
      rst      = 1'b1;
      mem_resp = 1'b1;
      #1;
      chk("ar_no_d_resp", d_resp, 1'b0);
      chk("ar_no_i_resp", i_resp, 1'b0);
      tick();
      mem_resp = 1'b0;
      chk("ar_idle_strobes", {mem_read, mem_write}, 2'b00);

      // ---------------- both caches request continuously for four transactions
      do_reset();
      i_read    = 1'b1;
      i_address = 32'h0000_0400;
      d_read    = 1'b1;
      d_address = 32'h0000_0800;
      for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
         exp_g = (t % 2 == 0);
`else
         exp_g = 1'b1;
`endif
         tick();
         chk($sformatf("cont%0d_grant", t), grant_sel, exp_g);
         chk($sformatf("cont%0d_addr", t), mem_address, exp_g ? d_address : i_address);
         mem_resp = 1'b1;
         #1;
         chk($sformatf("cont%0d_resp", t), {i_resp, d_resp}, exp_g ? 2'b01 : 2'b10);
         tick();
         mem_resp = 1'b0;
      end
      clear_inputs();
      tick();

      // ---------------- randomized transactions against a transaction-level model
      do_reset();
      last_d    = 1'b0;
      exp_wdata = '0;
      for (int n = 0; n < 200; n++) begin
         i_read    = 1'($urandom_range(0, 1));
         d_read    = 1'($urandom_range(0, 1));
         d_write   = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
         if (d_read && d_write) d_read = 1'b0;
         i_address = $urandom;
         d_address = $urandom;
         d_wdata   = rand_line();
         if (!i_read && !d_read && !d_write) begin
            mem_resp  = 1'b1;
            mem_rdata = rand_line();
            #1;
            chk("rnd_spurious", {i_resp, d_resp}, 2'b00);
            tick();
            mem_resp = 1'b0;
            chk("rnd_spurious_idle", {mem_read, mem_write}, 2'b00);
            continue;
         end
         if ((d_read || d_write) && i_read) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_d = ~last_d;
`else
            win_d = 1'b1;
`endif
         end else begin
            win_d = d_read || d_write;
         end
         is_wr = win_d && d_write;
         if (is_wr) exp_wdata = d_wdata;
         tick();
         chk("rnd_read", mem_read, !is_wr);
         chk("rnd_write", mem_write, is_wr);
         chk("rnd_grant", grant_sel, win_d);
         chk("rnd_addr", mem_address, win_d ? d_address : i_address);
         chk("rnd_wdata", mem_wdata, exp_wdata);
         pat = win_d ? {{(LW-AW){1'b0}}, d_address} : {{(LW-AW){1'b0}}, i_address};
         repeat ($urandom_range(0, 3)) begin
            i_address = $urandom;
            d_address = $urandom;
            d_wdata   = rand_line();
            tick();
         end
         chk("rnd_addr_hold", mem_address, pat[AW-1:0]);
         chk("rnd_wdata_hold", mem_wdata, exp_wdata);
         pat       = rand_line();
         mem_rdata = pat;
         mem_resp  = 1'b1;
         #1;
         chk("rnd_i_resp", i_resp, !win_d);
         chk("rnd_d_resp", d_resp, win_d);
         chk("rnd_i_rdata", i_rdata, win_d ? '0 : pat);
         chk("rnd_d_rdata", d_rdata, win_d ? pat : '0);
         tick();
         clear_inputs();
         chk("rnd_done", {mem_read, mem_write}, 2'b00);
         chk("rnd_grant_hold", grant_sel, win_d);
         last_d = win_d;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Arbitrates the single physical-memory port between the instruction cache (read-only) and the data cache (read/write) in the mp3 core.
- Holds one transaction at a time and registers the winner's address and write data.
- Drives grant_sel, the select of the line-width mux2 that steers memory traffic, and routes mem_resp/mem_rdata back to the granted cache only.

Parameters:
ADDR_W, 32, address width of all ports
LINE_W, 256, cache line width (rdata/wdata)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
i_read  in  1  icache line read request (level, held until i_resp)
i_address  in  ADDR_W  icache line address
i_rdata  out  LINE_W  line to icache
i_resp  out  1  icache completion pulse
d_read  in  1  dcache line read request (level)
d_write  in  1  dcache line write request (level)
d_address  in  ADDR_W  dcache line address
d_wdata  in  LINE_W  dcache writeback line
d_rdata  out  LINE_W  line to dcache
d_resp  out  1  dcache completion pulse
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_W  memory address (registered)
mem_wdata  out  LINE_W  memory write data (registered)
mem_rdata  in  LINE_W  memory read data
mem_resp  in  1  memory completion pulse
grant_sel  out  1  0 = icache owns port, 1 = dcache owns port

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Single state register.
- Reset (rst=0, async): state=IDLE. mem_read, mem_write, i_resp and d_resp are 0. mem_address, mem_wdata, i_rdata, d_rdata and grant_sel are 0. Any in-flight transaction is dropped without a response. The memory model is reset alongside.
- IDLE arbitration (default, fixed priority):
  - d_read|d_write present: go to SERVE_D.
  - Else if i_read present: go to SERVE_I.
  - Else stay in IDLE.
- On the grant edge:
  - Latch the winner's address into mem_address. For a dcache write, also latch d_wdata into mem_wdata.
  - Set grant_sel.
  - Latency: request seen in cycle N gives mem_read/mem_write=1 in cycle N+1.
- SERVE_x:
  - mem_read/mem_write, mem_address and mem_wdata stay stable until mem_resp.
  - Later changes on the requester inputs are ignored.
- Completion, mem_resp=1 in SERVE_x:
  - Granted x_resp=1 combinationally in the same cycle.
  - x_rdata=mem_rdata in that cycle; the non-granted rdata stays 0 and its resp stays 0.
  - Next edge: state=IDLE, strobes cleared.
  - grant_sel holds its last value in IDLE.
- Requesters must drop their request in the cycle after x_resp. A request still high in IDLE is treated as a new transaction.
- d_read and d_write both high: treated as a write (mem_write only). This is a protocol violation and the bench flags it.
- mem_resp while in IDLE: ignored; no x_resp is issued.
- mem_read and mem_write are never both 1. Exactly one transaction is outstanding at any time.
- Back-to-back: one IDLE cycle always separates consecutive transactions.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_grant flop (reset 0 = icache) is updated at each grant.
  - When both caches request in IDLE, the one not served last wins.
  - A single requester always wins.
- Undefined: fixed dcache priority; last_grant is not instantiated.

Test Plan:
- Reset: drive rst=0 mid-SERVE_D with mem_write=1 → mem_write=0 and grant_sel=0 immediately (no clock). After release, no d_resp is issued even if mem_resp pulses.
- Icache read alone: i_read=1, i_address=0x0000_0060 at cycle 0 → mem_read=1, mem_address=0x60, grant_sel=0 at cycle 1. Then mem_resp=1 with mem_rdata=0xA5…A5 at cycle 4 → i_resp=1, i_rdata=0xA5…A5, d_resp=0 in cycle 4; mem_read=0 at cycle 5.
- Conflict, fixed priority: i_read (0x100) and d_write (0x200, wdata 0x1234…) at cycle 0 → the dcache write is served first (mem_write, address 0x200). After d_resp, one IDLE cycle, then mem_read at 0x100 and i_resp.
- Conflict with ARB_ROUND_ROBIN_EN: both caches request continuously for four transactions → grants alternate D,I,D,I when starting from reset (last_grant=I). Without the macro → D,D,D,D while d requests persist.
- Spurious mem_resp in IDLE → i_resp=0 and d_resp=0, state remains IDLE.
- Input change during service: d_address changes from 0x200 to 0x300 while in SERVE_D → mem_address stays 0x200 until mem_resp.
